shared_bus_mux: RTL and testbench

- Downstream consumer of the two-client grant arbiter.
- Takes the registered gnt_0/gnt_1 and gives the granted client ownership of a single shared write bus.
- Moves that client's data beats through a one-entry output register using valid/ready handshakes.
- Ends ownership on last beat, burst limit, or grant loss, and pulses done back to the client so it drops its request.

---
 rtl/shared_bus_mux_pkg.sv | 24 ++
 rtl/shared_bus_mux_bus_out_reg.sv | 70 +++++++
 rtl/shared_bus_mux.sv | 141 ++++++++++++++
 tb/tb_shared_bus_mux.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_bus_mux_pkg.sv
// Shared types and defaults for the shared_bus_mux write-bus owner.
// Optional parity output is enabled with SHARED_BUS_MUX_PARITY_EN.
package shared_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN0    = 2'd1,
        OWN1    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic OWNER_0 = 1'b0;
    localparam logic OWNER_1 = 1'b1;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_BURST_MAX = 4;
    localparam int unsigned DEF_CNT_W     = 3;

    // Which client the current state belongs to; only meaningful in OWN0/OWN1.
    function automatic logic owner_of(input state_e s);
        return (s == OWN1) ? OWNER_1 : OWNER_0;
    endfunction

endpackage

// File: rtl/shared_bus_mux_bus_out_reg.sv
// One-entry output register: holds a beat with stable data until the bus accepts it.
// With SHARED_BUS_MUX_PARITY_EN defined, also registers even parity of the data.
module bus_out_reg
    import shared_bus_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              bus_ready,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data
`ifdef SHARED_BUS_MUX_PARITY_EN
    ,
    output logic              bus_parity
`endif
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A load only happens when the slot is empty or draining this cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (bus_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus_valid = valid_q;
    assign bus_data  = data_q;

`ifdef SHARED_BUS_MUX_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (load) begin
            parity_d = ^load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus_parity = parity_q;
`endif

endmodule

// File: rtl/shared_bus_mux.sv
// Gives the granted client ownership of the shared write bus and moves its beats.
// Define SHARED_BUS_MUX_PARITY_EN to add the registered bus_parity output.
module shared_bus_mux
    import shared_bus_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BURST_MAX = DEF_BURST_MAX,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic              c0_valid,
    input  logic [DATA_W-1:0] c0_data,
    input  logic              c0_last,
    output logic              c0_ready,
    input  logic              c1_valid,
    input  logic [DATA_W-1:0] c1_data,
    input  logic              c1_last,
    output logic              c1_ready,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    input  logic              bus_ready,
`ifdef SHARED_BUS_MUX_PARITY_EN
    output logic              bus_parity,
`endif
    output logic              done_0,
    output logic              done_1,
    output logic              abort,
    output logic              err_both
);

    localparam logic [CNT_W:0] BURST_LIM = (CNT_W + 1)'(BURST_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       done_q, done_d;
    logic             abort_q, abort_d;
    logic             err_both_q, err_both_d;

    logic [1:0]       gnt_a, valid_a, last_a, ready_a, accept_a;
    logic             owner;
    logic [CNT_W:0]   count_inc;
    logic             load;
    logic [DATA_W-1:0] load_data;

    assign gnt_a   = {gnt_1, gnt_0};
    assign valid_a = {c1_valid, c0_valid};
    assign last_a  = {c1_last, c0_last};
    assign owner   = owner_of(state_q);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_client
            localparam state_e OWN_ST = (gi == 0) ? OWN0 : OWN1;
            assign ready_a[gi]  = (state_q == OWN_ST) && gnt_a[gi] && (!bus_valid || bus_ready);
            assign accept_a[gi] = valid_a[gi] && ready_a[gi];
        end
    endgenerate

    assign load      = |accept_a;
    assign load_data = (owner == OWNER_1) ? c1_data : c0_data;
    assign count_inc = {1'b0, count_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = 2'b00;
        abort_d    = 1'b0;
        err_both_d = err_both_q | (gnt_0 & gnt_1);
        case (state_q)
            IDLE: begin
                // Client 0 wins a tie; a grant without valid data is ignored.
                if (gnt_0 && c0_valid) begin
                    state_d = OWN0;
                end else if (gnt_1 && c1_valid) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!gnt_a[owner]) begin
                    state_d        = RELEASE;
                    done_d[owner]  = 1'b1;
                    abort_d        = 1'b1;
                    count_d        = '0;
                end else if (accept_a[owner]) begin
                    if (last_a[owner] || (count_inc == BURST_LIM)) begin
                        state_d       = RELEASE;
                        done_d[owner] = 1'b1;
                        count_d       = '0;
                    end else begin
                        count_d = count_inc[CNT_W-1:0];
                    end
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            done_q     <= 2'b00;
            abort_q    <= 1'b0;
            err_both_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            err_both_q <= err_both_d;
        end
    end

    bus_out_reg #(
        .DATA_W(DATA_W)
    ) u_bus_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .bus_ready (bus_ready),
        .bus_valid (bus_valid),
        .bus_data  (bus_data)
`ifdef SHARED_BUS_MUX_PARITY_EN
        ,
        .bus_parity(bus_parity)
`endif
    );

    assign c0_ready = ready_a[0];
    assign c1_ready = ready_a[1];
    assign done_0   = done_q[0];
    assign done_1   = done_q[1];
    assign abort    = abort_q;
    assign err_both = err_both_q;

endmodule

// File: tb/tb_shared_bus_mux.sv
// Self-checking bench for shared_bus_mux: directed scenarios plus randomized bursts.
// Expected bus streams come from client queues truncated at last / burst limit / grant drop.
module tb_shared_bus_mux;

    localparam int DW = 8;
    localparam int BM = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          gnt_0 = 1'b0, gnt_1 = 1'b0;
    logic          c0_valid = 1'b0, c0_last = 1'b0, c1_valid = 1'b0, c1_last = 1'b0;
    logic [DW-1:0] c0_data = '0, c1_data = '0;
    logic          bus_ready = 1'b0;
    logic          c0_ready, c1_ready, bus_valid, done_0, done_1, abort, err_both;
    logic [DW-1:0] bus_data;
`ifdef SHARED_BUS_MUX_PARITY_EN
    logic          bus_parity;
`endif

    shared_bus_mux #(.DATA_W(DW), .BURST_MAX(BM), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .c0_valid(c0_valid), .c0_data(c0_data), .c0_last(c0_last), .c0_ready(c0_ready),
        .c1_valid(c1_valid), .c1_data(c1_data), .c1_last(c1_last), .c1_ready(c1_ready),
        .bus_valid(bus_valid), .bus_data(bus_data), .bus_ready(bus_ready),
`ifdef SHARED_BUS_MUX_PARITY_EN
        .bus_parity(bus_parity),
`endif
        .done_0(done_0), .done_1(done_1), .abort(abort), .err_both(err_both)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q0_d[$], q1_d[$], bus_log[$], exp_q[$];
    bit            q0_l[$], q1_l[$];
    bit            en0, en1, br_rand;
    int            br_pct, st_pct;
    logic          br_val;
    int            acc0, acc1, done0_cnt, done1_cnt, abort_cnt;
    logic          s_rdy0, s_rdy1, s_bv, s_done0, s_done1, s_abort, s_err;
    logic [DW-1:0] s_bd;
`ifdef SHARED_BUS_MUX_PARITY_EN
    logic          s_par;
`endif

    task automatic clear_scn();
        q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
        bus_log.delete(); exp_q.delete();
        en0 = 0; en1 = 0; br_rand = 0; br_val = 1'b1; br_pct = 100; st_pct = 0;
        acc0 = 0; acc1 = 0; done0_cnt = 0; done1_cnt = 0; abort_cnt = 0;
    endtask

    // One clock cycle of client/bus behaviour; called at posedge+1, returns at next posedge+1.
    task automatic step();
        c0_valid = en0 && (q0_d.size() > 0) && ($urandom_range(99) >= st_pct);
        c0_data  = (q0_d.size() > 0) ? q0_d[0] : '0;
        c0_last  = (q0_l.size() > 0) ? q0_l[0] : 1'b0;
        c1_valid = en1 && (q1_d.size() > 0) && ($urandom_range(99) >= st_pct);
        c1_data  = (q1_d.size() > 0) ? q1_d[0] : '0;
        c1_last  = (q1_l.size() > 0) ? q1_l[0] : 1'b0;
        bus_ready = br_rand ? ($urandom_range(99) < br_pct) : br_val;
        #1;
        s_rdy0 = c0_ready; s_rdy1 = c1_ready; s_bv = bus_valid; s_bd = bus_data;
        s_done0 = done_0; s_done1 = done_1; s_abort = abort; s_err = err_both;
`ifdef SHARED_BUS_MUX_PARITY_EN
        s_par = bus_parity;
`endif
        if (c0_valid && c0_ready) begin
            acc0++; void'(q0_d.pop_front()); void'(q0_l.pop_front());
        end
        if (c1_valid && c1_ready) begin
            acc1++; void'(q1_d.pop_front()); void'(q1_l.pop_front());
        end
        if (bus_valid && bus_ready) bus_log.push_back(bus_data);
        if (done_0) begin done0_cnt++; en0 = 0; end
        if (done_1) begin done1_cnt++; en1 = 0; end
        if (abort) abort_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus_valid, bus_data, done_0, done_1, abort, err_both, c0_ready, c1_ready} !== '0) begin
            failures++;
            $display("FAIL reset_values: got bv=%b bd=%h d0=%b d1=%b ab=%b err=%b r0=%b r1=%b required all 0",
                     bus_valid, bus_data, done_0, done_1, abort, err_both, c0_ready, c1_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_two_beat();
        clear_scn();
        q0_d = '{8'hA1, 8'hA2}; q0_l = '{1'b0, 1'b1};
        en0 = 1; gnt_0 = 1'b1;
        step();
        checks++;
        if (s_rdy0 !== 1'b0) begin failures++; $display("FAIL two_beat_entry_ready: got %b required 0", s_rdy0); end
        step();
        checks++;
        if (s_rdy0 !== 1'b1) begin failures++; $display("FAIL two_beat_first_ready: got %b required 1", s_rdy0); end
        step();
        checks++;
        if (s_bv !== 1'b1 || s_bd !== 8'hA1) begin failures++; $display("FAIL two_beat_beat0: got v=%b d=%h required v=1 d=a1", s_bv, s_bd); end
`ifdef SHARED_BUS_MUX_PARITY_EN
        checks++;
        if (s_par !== 1'b1) begin failures++; $display("FAIL two_beat_parity: got %b required 1", s_par); end
`endif
        step();
        checks++;
        if (s_bv !== 1'b1 || s_bd !== 8'hA2) begin failures++; $display("FAIL two_beat_beat1: got v=%b d=%h required v=1 d=a2", s_bv, s_bd); end
        checks++;
        if (s_done0 !== 1'b1 || s_abort !== 1'b0) begin failures++; $display("FAIL two_beat_done: got done0=%b abort=%b required 1/0", s_done0, s_abort); end
        step();
        checks++;
        if (s_done0 !== 1'b0) begin failures++; $display("FAIL two_beat_done_pulse: got %b required 0", s_done0); end
        repeat (3) step();
        checks++;
        if (done0_cnt != 1 || acc0 != 2 || bus_log.size() != 2) begin
            failures++;
            $display("FAIL two_beat_totals: got done=%0d acc=%0d beats=%0d required 1/2/2", done0_cnt, acc0, bus_log.size());
        end
        gnt_0 = 1'b0;
    endtask

    task automatic test_burst_limit();
        clear_scn();
        for (int i = 0; i < 6; i++) begin
            q1_d.push_back(DW'($urandom)); q1_l.push_back(1'b0);
            if (i < BM) exp_q.push_back(q1_d[i]);
        end
        en1 = 1; gnt_1 = 1'b1;
        for (int c = 0; c < 40 && done1_cnt == 0; c++) step();
        checks++;
        if (s_done1 !== 1'b1) begin failures++; $display("FAIL burst_done_seen: got %b required 1", s_done1); end
        checks++;
        if (s_rdy1 !== 1'b0) begin failures++; $display("FAIL burst_ready_after_limit: got %b required 0", s_rdy1); end
        gnt_1 = 1'b0;
        repeat (3) step();
        checks++;
        if (acc1 != BM || q1_d.size() != 6 - BM) begin failures++; $display("FAIL burst_accepts: got %0d required %0d", acc1, BM); end
        checks++;
        if (bus_log != exp_q) begin failures++; $display("FAIL burst_data: got %0d beats required %0d matching beats", bus_log.size(), exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d0;
        clear_scn();
        for (int i = 0; i < 3; i++) begin
            q0_d.push_back(DW'($urandom)); q0_l.push_back(i == 2);
            exp_q.push_back(q0_d[i]);
        end
        d0 = q0_d[0];
        en0 = 1; gnt_0 = 1'b1;
        step();
        step();
        br_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (s_rdy0 !== 1'b0 || s_bv !== 1'b1 || s_bd !== d0) begin
                failures++;
                $display("FAIL stall_hold_%0d: got r0=%b v=%b d=%h required 0/1/%h", i, s_rdy0, s_bv, s_bd, d0);
            end
        end
        br_val = 1'b1;
        for (int c = 0; c < 40 && done0_cnt == 0; c++) step();
        gnt_0 = 1'b0;
        repeat (3) step();
        checks++;
        if (acc0 != 3 || bus_log != exp_q) begin
            failures++;
            $display("FAIL stall_stream: got acc=%0d beats=%0d required 3/3 in order", acc0, bus_log.size());
        end
    endtask

    task automatic test_grant_loss();
        logic [DW-1:0] x0;
        clear_scn();
        for (int i = 0; i < 4; i++) begin q0_d.push_back(DW'($urandom)); q0_l.push_back(1'b0); end
        q1_d = '{8'h5A, 8'h5B}; q1_l = '{1'b0, 1'b1};
        x0 = q0_d[0];
        exp_q = '{x0, 8'h5A, 8'h5B};
        en0 = 1; gnt_0 = 1'b1;
        step();
        step();
        checks++;
        if (acc0 != 1) begin failures++; $display("FAIL loss_first_accept: got %0d required 1", acc0); end
        gnt_0 = 1'b0; gnt_1 = 1'b1; en1 = 1; br_val = 1'b0;
        step();
        checks++;
        if (s_rdy0 !== 1'b0) begin failures++; $display("FAIL loss_ready_drop: got %b required 0", s_rdy0); end
        br_val = 1'b1;
        step();
        checks++;
        if (s_done0 !== 1'b1 || s_abort !== 1'b1 || s_bv !== 1'b1 || s_bd !== x0) begin
            failures++;
            $display("FAIL loss_release: got d0=%b ab=%b v=%b d=%h required 1/1/1/%h", s_done0, s_abort, s_bv, s_bd, x0);
        end
        step();
        checks++;
        if (s_rdy1 !== 1'b0 || s_done0 !== 1'b0) begin failures++; $display("FAIL loss_idle_gap: got r1=%b d0=%b required 0/0", s_rdy1, s_done0); end
        step();
        checks++;
        if (s_rdy1 !== 1'b1) begin failures++; $display("FAIL loss_own1_ready: got %b required 1", s_rdy1); end
        for (int c = 0; c < 40 && done1_cnt == 0; c++) step();
        gnt_1 = 1'b0;
        repeat (3) step();
        checks++;
        if (done0_cnt != 1 || done1_cnt != 1 || abort_cnt != 1 || bus_log != exp_q) begin
            failures++;
            $display("FAIL loss_totals: got d0=%0d d1=%0d ab=%0d beats=%0d required 1/1/1/3", done0_cnt, done1_cnt, abort_cnt, bus_log.size());
        end
    endtask

    task automatic test_both_grants();
        bit saw_rdy1;
        clear_scn();
        q0_d = '{8'h3C}; q0_l = '{1'b1};
        q1_d = '{8'hC3}; q1_l = '{1'b1};
        exp_q = '{8'h3C, 8'hC3};
        en0 = 1; en1 = 1; gnt_0 = 1'b1; gnt_1 = 1'b1;
        saw_rdy1 = 0;
        step();
        step();
        checks++;
        if (s_err !== 1'b1 || s_rdy0 !== 1'b1) begin failures++; $display("FAIL both_tie: got err=%b r0=%b required 1/1", s_err, s_rdy0); end
        for (int c = 0; c < 40 && done0_cnt == 0; c++) begin
            if (s_rdy1) saw_rdy1 = 1;
            step();
        end
        checks++;
        if (saw_rdy1 || s_rdy1 !== 1'b0) begin failures++; $display("FAIL both_client1_ready: got %b required 0", saw_rdy1 | s_rdy1); end
        gnt_0 = 1'b0;
        for (int c = 0; c < 40 && done1_cnt == 0; c++) step();
        gnt_1 = 1'b0;
        repeat (3) step();
        checks++;
        if (bus_log != exp_q) begin failures++; $display("FAIL both_stream: got %0d beats required 2 in order", bus_log.size()); end
        checks++;
        if (s_err !== 1'b1) begin failures++; $display("FAIL both_err_sticky: got %b required 1", s_err); end
    endtask

    task automatic test_reset_mid_burst();
        clear_scn();
        for (int i = 0; i < 3; i++) begin q0_d.push_back(DW'($urandom)); q0_l.push_back(1'b0); end
        en0 = 1; gnt_0 = 1'b1;
        step();
        step();
        br_val = 1'b0;
        step();
        checks++;
        if (s_bv !== 1'b1) begin failures++; $display("FAIL rst_precondition: got bv=%b required 1", s_bv); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_valid, bus_data, done_0, done_1, abort, err_both, c0_ready, c1_ready} !== '0) begin
            failures++;
            $display("FAIL rst_async_clear: got bv=%b bd=%h d0=%b d1=%b ab=%b err=%b r0=%b r1=%b required all 0",
                     bus_valid, bus_data, done_0, done_1, abort, err_both, c0_ready, c1_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_scn();
        gnt_0 = 1'b0;
        repeat (3) step();
        checks++;
        if (done0_cnt != 0 || abort_cnt != 0 || s_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done: got d0=%0d ab=%0d err=%b required 0/0/0", done0_cnt, abort_cnt, s_err);
        end
        q0_d = '{8'h77}; q0_l = '{1'b1};
        en0 = 1; gnt_0 = 1'b1;
        step();
        checks++;
        if (s_rdy0 !== 1'b0) begin failures++; $display("FAIL rst_idle_entry: got %b required 0", s_rdy0); end
        step();
        checks++;
        if (s_rdy0 !== 1'b1) begin failures++; $display("FAIL rst_own_ready: got %b required 1", s_rdy0); end
        for (int c = 0; c < 20 && done0_cnt == 0; c++) step();
        gnt_0 = 1'b0;
        repeat (3) step();
        checks++;
        if (bus_log.size() != 1 || bus_log[0] !== 8'h77) begin
            failures++;
            $display("FAIL rst_after_beat: got %0d beats required 1 of 77", bus_log.size());
        end
    endtask

    task automatic test_random_bursts();
        int cl, lastpos, k, lim, acc, dcnt;
        bit drop, ok;
        for (int it = 0; it < 24; it++) begin
            clear_scn();
            cl      = $urandom_range(1);
            lastpos = $urandom_range(6);
            k       = (lastpos < 6 && lastpos + 1 < BM) ? lastpos + 1 : BM;
            drop    = ($urandom_range(3) == 0) && (k > 1);
            lim     = drop ? $urandom_range(k - 1, 1) : k;
            for (int i = 0; i < 6; i++) begin
                logic [DW-1:0] d;
                d = DW'($urandom);
                if (cl == 0) begin q0_d.push_back(d); q0_l.push_back(i == lastpos); end
                else begin q1_d.push_back(d); q1_l.push_back(i == lastpos); end
                if (i < lim) exp_q.push_back(d);
            end
            br_rand = 1; br_pct = $urandom_range(100, 30); st_pct = $urandom_range(40);
            if (cl == 0) begin en0 = 1; gnt_0 = 1'b1; end else begin en1 = 1; gnt_1 = 1'b1; end
            dcnt = 0;
            for (int c = 0; c < 300 && dcnt == 0; c++) begin
                step();
                acc  = (cl == 0) ? acc0 : acc1;
                dcnt = (cl == 0) ? done0_cnt : done1_cnt;
                if (drop && acc == lim) begin gnt_0 = 1'b0; gnt_1 = 1'b0; end
            end
            gnt_0 = 1'b0; gnt_1 = 1'b0; br_rand = 0; br_val = 1'b1;
            repeat (3) step();
            acc = (cl == 0) ? acc0 : acc1;
            ok = (bus_log.size() == exp_q.size());
            for (int i = 0; i < bus_log.size() && ok; i++) if (bus_log[i] !== exp_q[i]) ok = 0;
            checks++;
            if (!ok || acc != lim) begin
                failures++;
                $display("FAIL rand_%0d_stream: got acc=%0d beats=%0d required %0d in order (client %0d)", it, acc, bus_log.size(), lim, cl);
            end
            checks++;
            if (dcnt != 1 || abort_cnt != int'(drop)) begin
                failures++;
                $display("FAIL rand_%0d_done: got done=%0d abort=%0d required 1/%0d", it, dcnt, abort_cnt, drop);
            end
        end
    endtask

    initial begin
        clear_scn();
        test_reset();
        test_two_beat();
        test_burst_limit();
        test_backpressure();
        test_grant_loss();
        test_both_grants();
        test_reset_mid_burst();
        test_random_bursts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
